button_debouncer: RTL and testbench

- Conditions already-synchronized button/switch inputs from the 2-flop synchronizer.
- A shared sample timer paces per-channel saturating counters, producing a stable debounced level and a one-cycle press pulse per channel.
- Sits between the synchronizer and the user-logic FSMs in the 125 MHz clock domain.

---
 rtl/button_pkg.sv | 34 +++
 rtl/button_debouncer_sample_tick_gen.sv | 48 ++++
 rtl/button_debouncer.sv | 106 ++++++++++
 tb/tb_button_debouncer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// ============================================================================
// Module      : button_pkg
// Description : Shared constants for the button debouncer slice: clock
//               frequency, production timing defaults and reduced
//               simulation-scale timing constants.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : none (package)
// ============================================================================
`default_nettype none

package button_pkg;

    // System clock of the domain the debouncer lives in.
    localparam int CLK_FREQ_HZ = 125_000_000;

    // 500 us sample period at 125 MHz.
    localparam int DEFAULT_SAMPLE_CNT_MAX = 62500;

    // 200 consecutive high samples (100 ms) declare a press.
    localparam int DEFAULT_PULSE_CNT_MAX = 200;

    // Shortened timing so a testbench reaches a press in a handful of cycles.
    localparam int SIM_SAMPLE_CNT_MAX = 4;
    localparam int SIM_PULSE_CNT_MAX  = 3;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int count_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage : button_pkg

`default_nettype wire

// File: rtl/button_debouncer_sample_tick_gen.sv
// ============================================================================
// Module      : sample_tick_gen
// Description : Free-running sample timer. Counts 0..SAMPLE_CNT_MAX-1 and
//               wraps; tick is high for the single cycle in which the timer
//               holds SAMPLE_CNT_MAX-1, so the first tick falls in the
//               SAMPLE_CNT_MAX-th cycle after reset release.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk  - system clock
//               rst  - asynchronous active-high reset
//               tick - one-cycle sample strobe every SAMPLE_CNT_MAX cycles
// ============================================================================
`default_nettype none

module sample_tick_gen #(
    parameter int SAMPLE_CNT_MAX = 62500
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int             c_TIMER_W    = $clog2(SAMPLE_CNT_MAX);
    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST = c_TIMER_W'(SAMPLE_CNT_MAX - 1);

    logic [c_TIMER_W-1:0] timer_q;
    logic [c_TIMER_W-1:0] timer_d;

    assign tick = (timer_q == c_TIMER_LAST);

    always_comb begin
        timer_d = timer_q + 1'b1;
        if (tick) begin
            timer_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

endmodule : sample_tick_gen

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// Module      : button_debouncer
// Description : Debounces WIDTH already-synchronized inputs. A shared sample
//               timer paces per-channel saturating counters; a channel is
//               declared stable-high once PULSE_CNT_MAX consecutive sample
//               ticks have seen it high. Any low cycle clears the channel.
//               A one-cycle press_pulse marks each debounced rising edge.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports       : clk           - system clock (125 MHz)
//               rst           - asynchronous active-high reset
//               sync_in       - [WIDTH] synchronized raw inputs
//               debounced     - [WIDTH] stable level per channel
//               press_pulse   - [WIDTH] one cycle on each debounced rise
//               release_pulse - [WIDTH] one cycle on each debounced fall
//                               (only with BUTTON_DEBOUNCER_RELEASE_PULSE_EN)
// Config      : `define BUTTON_DEBOUNCER_RELEASE_PULSE_EN adds release_pulse.
// ============================================================================
`default_nettype none

module button_debouncer
    import button_pkg::*;
#(
    parameter int WIDTH          = 1,
    parameter int SAMPLE_CNT_MAX = DEFAULT_SAMPLE_CNT_MAX,
    parameter int PULSE_CNT_MAX  = DEFAULT_PULSE_CNT_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] debounced,
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
    output logic [WIDTH-1:0] press_pulse,
    output logic [WIDTH-1:0] release_pulse
`else
    output logic [WIDTH-1:0] press_pulse
`endif
);

    localparam int                  c_CNT_W    = count_width(PULSE_CNT_MAX);
    localparam logic [c_CNT_W-1:0]  c_CNT_FULL = c_CNT_W'(PULSE_CNT_MAX);

    logic w_sample_tick;

    sample_tick_gen #(
        .SAMPLE_CNT_MAX(SAMPLE_CNT_MAX)
    ) u_sample_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(w_sample_tick)
    );

    for (genvar i = 0; i < WIDTH; i++) begin : g_channel
        logic [c_CNT_W-1:0] cnt_q;
        logic [c_CNT_W-1:0] cnt_d;
        logic               press_q;
        logic               w_deb_now;
        logic               w_deb_next;

        // A low input wins over everything, on every cycle, so a single
        // glitch low throws away all accumulated samples.
        always_comb begin
            cnt_d = cnt_q;
            if (!sync_in[i]) begin
                cnt_d = '0;
            end else if (w_sample_tick && (cnt_q < c_CNT_FULL)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        // The debounced level is the saturated state of the counter itself,
        // so it needs no separate flop and can never disagree with the count.
        assign w_deb_now  = (cnt_q == c_CNT_FULL);
        assign w_deb_next = (cnt_d == c_CNT_FULL);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q   <= '0;
                press_q <= 1'b0;
            end else begin
                cnt_q   <= cnt_d;
                press_q <= w_deb_next & ~w_deb_now;
            end
        end

        assign debounced[i]   = w_deb_now;
        assign press_pulse[i] = press_q;

`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
        logic release_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                release_q <= 1'b0;
            end else begin
                release_q <= ~w_deb_next & w_deb_now;
            end
        end

        assign release_pulse[i] = release_q;
`endif
    end

endmodule : button_debouncer

`default_nettype wire

// File: tb/tb_button_debouncer.sv
// ============================================================================
// Module      : tb_button_debouncer
// Description : Self-checking bench for button_debouncer (WIDTH=2, reduced
//               timing). Directed table vectors, hand-written corner-case
//               sequences and a randomized run, all compared against a
//               reference model that derives the debounced level from the
//               edge index of the last low sample and the tick count since.
// Revision    : 1.0 - initial release
// Config      : honours BUTTON_DEBOUNCER_RELEASE_PULSE_EN.
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_button_debouncer;
    import button_pkg::*;

    localparam int c_W = 2;
    localparam int c_S = SIM_SAMPLE_CNT_MAX;
    localparam int c_P = SIM_PULSE_CNT_MAX;

    logic           clk;
    logic           rst;
    logic [c_W-1:0] sync_in;
    logic [c_W-1:0] debounced;
    logic [c_W-1:0] press_pulse;
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
    logic [c_W-1:0] release_pulse;
`endif

    button_debouncer #(
        .WIDTH         (c_W),
        .SAMPLE_CNT_MAX(c_S),
        .PULSE_CNT_MAX (c_P)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sync_in      (sync_in),
        .debounced    (debounced),
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse)
`else
        .press_pulse  (press_pulse)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: edges since reset release, and the edge at
    // which each channel last sampled low (0 = reset release).
    int             edge_n;
    int             last_low [c_W];
    logic [c_W-1:0] prev_deb;
    logic [c_W-1:0] exp_deb;
    logic [c_W-1:0] exp_press;
    logic [c_W-1:0] exp_rel;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got=%0h expected=%0h", name, edge_n, got, exp);
        end
    endtask

    task automatic model_reset();
        edge_n   = 0;
        prev_deb = '0;
        for (int c = 0; c < c_W; c++) last_low[c] = 0;
    endtask

    // Ticks land on edges that are multiples of c_S; a channel is debounced
    // once at least c_P ticks have occurred since its last low sample.
    task automatic model_edge();
        edge_n++;
        for (int c = 0; c < c_W; c++) begin
            if (!sync_in[c]) last_low[c] = edge_n;
            exp_deb[c] = ((edge_n / c_S) - (last_low[c] / c_S)) >= c_P;
        end
        exp_press = exp_deb & ~prev_deb;
        exp_rel   = ~exp_deb & prev_deb;
        prev_deb  = exp_deb;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_deb", 32'(debounced), 32'(exp_deb));
        chk("model_press", 32'(press_pulse), 32'(exp_press));
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
        chk("model_release", 32'(release_pulse), 32'(exp_rel));
`endif
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_deb"}, 32'(debounced), 32'd0);
        chk({name, "_press"}, 32'(press_pulse), 32'd0);
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
        chk({name, "_release"}, 32'(release_pulse), 32'd0);
`endif
    endtask

    // Called ~1 ns after a posedge: asserts rst mid-cycle, checks the async
    // clear, holds for two edges and releases away from the clock edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst_mid");
        repeat (2) @(posedge clk);
        #3 chk_all_zero("async_rst_held");
        rst = 1'b0;
        model_reset();
        #1 chk_all_zero("async_rst_after");
    endtask

    typedef struct {
        logic [c_W-1:0] in;
        int             n;
        logic [c_W-1:0] deb;
        logic [c_W-1:0] press;
        logic [c_W-1:0] rel;
    } vec_t;

    vec_t tbl [7];
    logic any_deb0;
    logic [c_W-1:0] rnd;

    initial begin
        // in, edges to apply, expected deb/press/release after the last edge
        tbl[0] = '{2'b01, 11, 2'b00, 2'b00, 2'b00};
        tbl[1] = '{2'b01,  1, 2'b01, 2'b01, 2'b00};
        tbl[2] = '{2'b01,  1, 2'b01, 2'b00, 2'b00};
        tbl[3] = '{2'b01, 10, 2'b01, 2'b00, 2'b00};
        tbl[4] = '{2'b00,  1, 2'b00, 2'b00, 2'b01};
        tbl[5] = '{2'b10, 11, 2'b00, 2'b00, 2'b00};
        tbl[6] = '{2'b10,  1, 2'b10, 2'b10, 2'b00};

        rst     = 1'b1;
        sync_in = '0;
        model_reset();
        exp_deb = '0; exp_press = '0; exp_rel = '0;
        #1 chk_all_zero("reset_initial");
        repeat (2) @(posedge clk);
        #3 chk_all_zero("reset_held");
        rst = 1'b0;
        #1 chk_all_zero("reset_released");

        // Directed table: press on ch0, hold, release, then press on ch1.
        for (int v = 0; v < 7; v++) begin
            sync_in = tbl[v].in;
            repeat (tbl[v].n) step();
            chk($sformatf("tbl%0d_deb", v), 32'(debounced), 32'(tbl[v].deb));
            chk($sformatf("tbl%0d_press", v), 32'(press_pulse), 32'(tbl[v].press));
`ifdef BUTTON_DEBOUNCER_RELEASE_PULSE_EN
            chk($sformatf("tbl%0d_release", v), 32'(release_pulse), 32'(tbl[v].rel));
`endif
        end

        // One-cycle glitch low at edge 10 restarts the count.
        async_reset();
        sync_in = 2'b01;
        repeat (9) step();
        sync_in = 2'b00;
        step();
        sync_in = 2'b01;
        repeat (6) step();
        chk("glitch_deb_e16", 32'(debounced), 32'd0);
        repeat (3) step();
        chk("glitch_press_e19", 32'(press_pulse), 32'd0);
        step();
        chk("glitch_deb_e20", 32'(debounced), 32'd1);
        chk("glitch_press_e20", 32'(press_pulse), 32'd1);
        step();
        chk("glitch_press_e21", 32'(press_pulse), 32'd0);

        // Reset in the middle of a count discards all progress.
        async_reset();
        sync_in = 2'b01;
        repeat (10) step();
        async_reset();
        repeat (11) step();
        chk("midrst_deb_e11", 32'(debounced), 32'd0);
        step();
        chk("midrst_deb_e12", 32'(debounced), 32'd1);
        chk("midrst_press_e12", 32'(press_pulse), 32'd1);

        // Channel 1 held high while channel 0 toggles every 3 edges.
        async_reset();
        any_deb0 = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            sync_in = {1'b1, 1'(((k - 1) / 3) % 2 == 0)};
            step();
            if (debounced[0] || press_pulse[0]) any_deb0 = 1'b1;
            if (k == 11) chk("toggle_deb1_e11", 32'(debounced[1]), 32'd0);
            if (k == 12) begin
                chk("toggle_deb1_e12", 32'(debounced[1]), 32'd1);
                chk("toggle_press1_e12", 32'(press_pulse[1]), 32'd1);
            end
        end
        chk("toggle_ch0_never", 32'(any_deb0), 32'd0);

        // Randomized: each channel flips occasionally so presses, releases
        // and glitches all occur; with a rare async reset thrown in.
        async_reset();
        rnd = '0;
        for (int k = 0; k < 1500; k++) begin
            for (int c = 0; c < c_W; c++) begin
                if ($urandom_range(0, 29) == 0) rnd[c] = ~rnd[c];
            end
            sync_in = rnd;
            if ($urandom_range(0, 499) == 0) async_reset();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_button_debouncer

`default_nettype wire
